// File: rtl/elastic_merge_arbiter_pkg.sv
// Shared constants, FSM encoding and pointer helper for the elastic merge arbiter.
// Optional grant counters are enabled with ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN.
package elastic_merge_arbiter_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned INPUT_NUM            = 4;
  localparam int unsigned INPUT_NUM_BIT_LENGTH = 2;
  localparam int unsigned GRANT_COUNT_WIDTH    = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Modulo increment done with an explicit compare so non-power-of-2 counts wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/elastic_merge_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
// Falls back to ptr when nothing is valid.
module rr_priority_picker #(
  parameter int unsigned INPUT_NUM            = elastic_merge_arbiter_pkg::INPUT_NUM,
  parameter int unsigned INPUT_NUM_BIT_LENGTH = elastic_merge_arbiter_pkg::INPUT_NUM_BIT_LENGTH
) (
  input  logic [INPUT_NUM-1:0]            i_valid,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0] i_ptr,
  output logic [INPUT_NUM_BIT_LENGTH-1:0] o_grant_c,
  output logic                            o_any_valid_c
);

  localparam int unsigned BW = INPUT_NUM_BIT_LENGTH;

  // Scan offsets from farthest to nearest so the nearest valid requester is assigned last.
  always_comb begin : pick
    int unsigned w_idx;
    w_idx         = 0;
    o_grant_c     = i_ptr;
    o_any_valid_c = |i_valid;
    for (int k = INPUT_NUM - 1; k >= 0; k--) begin
      w_idx = 32'(i_ptr) + 32'(k);
      if (w_idx > INPUT_NUM - 1) begin
        w_idx = w_idx - INPUT_NUM;
      end
      for (int j = 0; j < INPUT_NUM; j++) begin
        if (i_valid[j] && (32'(j) == w_idx)) begin
          o_grant_c = BW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/elastic_merge_arbiter.sv
// Round-robin merge of INPUT_NUM valid/stop producers onto one elastic channel; grant locks on stall.
// Define ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN to add saturating per-requester transfer counters.
module elastic_merge_arbiter #(
  parameter int unsigned DATA_WIDTH           = elastic_merge_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned INPUT_NUM            = elastic_merge_arbiter_pkg::INPUT_NUM,
  parameter int unsigned INPUT_NUM_BIT_LENGTH = elastic_merge_arbiter_pkg::INPUT_NUM_BIT_LENGTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [INPUT_NUM-1:0][DATA_WIDTH-1:0] data_input,
  input  logic [INPUT_NUM-1:0]                 valid_input,
  output logic [INPUT_NUM-1:0]                 stop_input,
  output logic [DATA_WIDTH-1:0]                data_output,
  output logic                                 valid_output,
  input  logic                                 stop_output,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]      input_data_index
`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
  ,
  output logic [INPUT_NUM-1:0][15:0]           grant_count
`endif
);

  import elastic_merge_arbiter_pkg::*;

  localparam int unsigned BW = INPUT_NUM_BIT_LENGTH;

  state_e        r_state;
  state_e        w_state_next;
  logic [BW-1:0] r_ptr;
  logic [BW-1:0] w_ptr_next;
  logic [BW-1:0] r_lock_idx;
  logic [BW-1:0] w_lock_idx_next;
  logic [BW-1:0] w_pick_grant;
  logic [BW-1:0] w_grant;
  logic          w_any_valid;

  rr_priority_picker #(
    .INPUT_NUM            (INPUT_NUM),
    .INPUT_NUM_BIT_LENGTH (INPUT_NUM_BIT_LENGTH)
  ) u_picker (
    .i_valid       (valid_input),
    .i_ptr         (r_ptr),
    .o_grant_c     (w_pick_grant),
    .o_any_valid_c (w_any_valid)
  );

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_lock_idx <= w_lock_idx_next;
    end
  end

  // Index is pinned to 0 while reset is held, independent of which inputs are valid.
  always_comb begin : grant_sel
    w_grant = w_pick_grant;
    if (reset) begin
      w_grant = '0;
    end else if (r_state == LOCKED) begin
      w_grant = r_lock_idx;
    end
  end

  always_comb begin : out_mux
    input_data_index = w_grant;
    data_output      = '0;
    valid_output     = 1'b0;
    stop_input       = '1;
    for (int j = 0; j < INPUT_NUM; j++) begin
      if (w_grant == BW'(j)) begin
        data_output   = data_input[j];
        valid_output  = valid_input[j];
        stop_input[j] = stop_output;
      end
    end
  end

  always_comb begin : next_state
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_lock_idx_next = r_lock_idx;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          if (!stop_output) begin
            w_ptr_next = BW'(wrap_inc(32'(w_grant), INPUT_NUM));
          end else begin
            w_state_next    = LOCKED;
            w_lock_idx_next = w_grant;
          end
        end
      end
      LOCKED: begin
        // A producer dropping valid while stalled releases the lock without advancing ptr.
        if (!valid_output) begin
          w_state_next = IDLE;
        end else if (!stop_output) begin
          w_state_next = IDLE;
          w_ptr_next   = BW'(wrap_inc(32'(r_lock_idx), INPUT_NUM));
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
  logic [INPUT_NUM-1:0][15:0] r_grant_count;
  logic                       w_transfer;

  assign w_transfer  = valid_output & ~stop_output;
  assign grant_count = r_grant_count;

  always_ff @(posedge clk or posedge reset) begin : grant_counters
    if (reset) begin
      r_grant_count <= '0;
    end else begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (w_transfer && (w_grant == BW'(i)) && (r_grant_count[i] != 16'hFFFF)) begin
          r_grant_count[i] <= r_grant_count[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_elastic_merge_arbiter.sv
// Self-checking bench for elastic_merge_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of the round-robin/lock rules.
module tb_elastic_merge_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0][DW-1:0] din;
  logic [N-1:0]         vin;
  logic [N-1:0]         sin;
  logic [DW-1:0]        dout;
  logic                 vout;
  logic                 sout;
  logic [1:0]           idx;

  logic [2:0][DW-1:0]   din3;
  logic [2:0]           vin3;
  logic [2:0]           sin3;
  logic [DW-1:0]        dout3;
  logic                 vout3;
  logic                 sout3;
  logic [1:0]           idx3;

`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
  logic [N-1:0][15:0]   gc;
  logic [2:0][15:0]     gc3;
`endif

  elastic_merge_arbiter #(.DATA_WIDTH(DW), .INPUT_NUM(N), .INPUT_NUM_BIT_LENGTH(2)) dut (
    .clk(clk), .reset(reset), .data_input(din), .valid_input(vin), .stop_input(sin),
    .data_output(dout), .valid_output(vout), .stop_output(sout), .input_data_index(idx)
`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
    , .grant_count(gc)
`endif
  );

  elastic_merge_arbiter #(.DATA_WIDTH(DW), .INPUT_NUM(3), .INPUT_NUM_BIT_LENGTH(2)) dut3 (
    .clk(clk), .reset(reset), .data_input(din3), .valid_input(vin3), .stop_input(sin3),
    .data_output(dout3), .valid_output(vout3), .stop_output(sout3), .input_data_index(idx3)
`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
    , .grant_count(gc3)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: round-robin base, lock flag, locked requester, transfer counts.
  int m_ptr;
  bit m_locked;
  int m_lock;
  int m_cnt[N];

  task automatic model_reset();
    m_ptr    = 0;
    m_locked = 0;
    m_lock   = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic int exp_grant();
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (vin[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return m_ptr;
  endfunction

  task automatic model_step(input int g);
    if (m_locked) begin
      if (!vin[m_lock]) begin
        m_locked = 0;
      end else if (!sout) begin
        m_locked = 0;
        m_ptr    = (m_lock + 1) % N;
        if (m_cnt[m_lock] < 65535) m_cnt[m_lock]++;
      end
    end else if (vin[g]) begin
      if (!sout) begin
        m_ptr = (g + 1) % N;
        if (m_cnt[g] < 65535) m_cnt[g]++;
      end else begin
        m_locked = 1;
        m_lock   = g;
      end
    end
  endtask

  // Called at posedge+1 with vin/sout already driven; checks outputs, then advances one clock.
  task automatic check_cycle(input string name);
    int           g;
    logic [N-1:0] es;
    for (int i = 0; i < N; i++) din[i] = $urandom;
    #3;
    g     = exp_grant();
    es    = '1;
    es[g] = sout;
    checks++;
    if (idx !== 2'(g)) begin
      failures++;
      $display("FAIL %s index got=%0d want=%0d", name, idx, g);
    end
    checks++;
    if (vout !== vin[g]) begin
      failures++;
      $display("FAIL %s valid_output got=%b want=%b", name, vout, vin[g]);
    end
    checks++;
    if (dout !== din[g]) begin
      failures++;
      $display("FAIL %s data_output got=%h want=%h", name, dout, din[g]);
    end
    checks++;
    if (sin !== es) begin
      failures++;
      $display("FAIL %s stop_input got=%b want=%b", name, sin, es);
    end
`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gc[i] !== 16'(m_cnt[i])) begin
        failures++;
        $display("FAIL %s grant_count[%0d] got=%0d want=%0d", name, i, gc[i], m_cnt[i]);
      end
    end
`endif
    @(posedge clk);
    model_step(g);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vin   = '0;
    sout  = 1'b0;
    vin3  = '0;
    sout3 = 1'b0;
    din3  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    vin  = 4'b1111;
    sout = 1'b0;
    check_cycle("pre_reset0");
    check_cycle("pre_reset1");
    // Asynchronous assertion mid-cycle with ptr already advanced to 2.
    vin  = 4'b0101;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_index got=%0d want=0", idx);
    end
    checks++;
    if (vout !== 1'b1) begin
      failures++;
      $display("FAIL reset_valid got=%b want=1", vout);
    end
    sout = 1'b1;
    vin  = 4'b0000;
    #1;
    checks++;
    if (sin !== 4'b1111 || vout !== 1'b0) begin
      failures++;
      $display("FAIL reset_stop got=%b/%b want=1111/0", sin, vout);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sout  = 1'b0;
  endtask

  task automatic test_single_request();
    do_reset();
    vin  = 4'b0100;
    sout = 1'b0;
    #3;
    checks++;
    if (idx !== 2'd2 || sin !== 4'b1011) begin
      failures++;
      $display("FAIL single_req got idx=%0d stop=%b want idx=2 stop=1011", idx, sin);
    end
    #(-0);
    check_cycle("single_req");
    vin = 4'b0000;
    #3;
    checks++;
    if (idx !== 2'd3) begin
      failures++;
      $display("FAIL single_req_ptr got=%0d want=3", idx);
    end
    check_cycle("single_req_idle");
  endtask

  task automatic test_all_valid();
    do_reset();
    vin  = 4'b1111;
    sout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #3;
      checks++;
      if (idx !== 2'(i % 4) || sin !== ~(4'b0001 << (i % 4))) begin
        failures++;
        $display("FAIL all_valid cycle %0d got idx=%0d stop=%b want idx=%0d", i, idx, sin, i % 4);
      end
      check_cycle("all_valid");
    end
  endtask

  task automatic test_stall_lock();
    do_reset();
    vin  = 4'b0010;
    sout = 1'b1;
    check_cycle("stall_enter");
    vin = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (idx !== 2'd1 || sin[0] !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold got idx=%0d stop0=%b want idx=1 stop0=1", idx, sin[0]);
      end
      check_cycle("stall_hold");
    end
    sout = 1'b0;
    check_cycle("stall_release");
    #3;
    checks++;
    if (idx !== 2'd2) begin
      failures++;
      $display("FAIL stall_next got=%0d want=2", idx);
    end
    check_cycle("stall_next");
  endtask

  task automatic test_wrap();
    int exp_seq[3] = '{0, 1, 0};
    do_reset();
    vin3  = 3'b010;
    sout3 = 1'b0;
    #3;
    checks++;
    if (idx3 !== 2'd1) begin
      failures++;
      $display("FAIL wrap_setup got=%0d want=1", idx3);
    end
    @(posedge clk);
    #1;
    vin3 = 3'b011;
    for (int i = 0; i < 3; i++) begin
      din3[0] = $urandom;
      din3[1] = $urandom;
      din3[2] = $urandom;
      #3;
      checks++;
      if (idx3 !== 2'(exp_seq[i]) || dout3 !== din3[exp_seq[i]] || vout3 !== 1'b1) begin
        failures++;
        $display("FAIL wrap step %0d got idx=%0d want %0d", i, idx3, exp_seq[i]);
      end
      @(posedge clk);
      #1;
    end
    vin3 = '0;
  endtask

  task automatic test_protocol_violation();
    do_reset();
    vin  = 4'b1000;
    sout = 1'b1;
    check_cycle("viol_lock");
    vin = 4'b0000;
    check_cycle("viol_drop");
    check_cycle("viol_idle");
    vin = 4'b0110;
    #3;
    checks++;
    if (idx !== 2'd1) begin
      failures++;
      $display("FAIL viol_ptr got=%0d want=1", idx);
    end
    check_cycle("viol_after");
  endtask

  task automatic test_reset_in_locked();
    do_reset();
    vin  = 4'b0100;
    sout = 1'b1;
    check_cycle("rl_lock");
    #1;
    checks++;
    if (idx !== 2'd2) begin
      failures++;
      $display("FAIL rl_locked got=%0d want=2", idx);
    end
    vin   = 4'b0000;
    sout  = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (idx !== 2'd0 || sin !== 4'b1110) begin
      failures++;
      $display("FAIL rl_async got idx=%0d stop=%b want idx=0 stop=1110", idx, sin);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    vin = 4'b0100;
    check_cycle("rl_after");
  endtask

  task automatic test_random();
    do_reset();
    vin  = '0;
    sout = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) vin = 4'($urandom);
      sout = ($urandom_range(0, 9) < 3);
      check_cycle("random");
    end
  endtask

`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
  task automatic test_grant_count();
    logic stall_seq[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    vin = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      sout = stall_seq[i];
      check_cycle("gc_run");
    end
    checks++;
    if (gc[3] !== 16'd5 || gc[0] !== 16'd0 || gc[1] !== 16'd0 || gc[2] !== 16'd0) begin
      failures++;
      $display("FAIL gc_five got=%0d/%0d/%0d/%0d want=5/0/0/0", gc[3], gc[2], gc[1], gc[0]);
    end
    do_reset();
    vin  = 4'b0001;
    sout = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      @(posedge clk);
    end
    #1;
    checks++;
    if (gc[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL gc_saturate got=%h want=ffff", gc[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gc[0] !== 16'hFFFF || gc[1] !== 16'd0) begin
      failures++;
      $display("FAIL gc_hold got=%h/%h want=ffff/0000", gc[0], gc[1]);
    end
    vin = '0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    din   = '0;
    vin   = '0;
    sout  = 1'b0;
    din3  = '0;
    vin3  = '0;
    sout3 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_request();
    test_all_valid();
    test_stall_lock();
    test_wrap();
    test_protocol_violation();
    test_reset_in_locked();
    test_random();
`ifdef ELASTIC_MERGE_ARBITER_GRANT_COUNT_EN
    test_grant_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
